// File: rtl/modmult_sched_pkg.sv
// Shared types and default constants for the modular-multiply scheduler.
package modmult_sched_pkg;

    localparam int DEF_PIPE_LAT = 7;
    localparam int DEF_MODULUS  = 177147;
    localparam int TAG_ID_W     = 8;

    // Travels alongside each operand through the external pipeline.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                err;
    } tag_t;

endpackage

// File: rtl/modmult_rsp_fifo.sv
// Result FIFO with occupancy count; a write into a full FIFO is accepted when a pop happens the same cycle.
module modmult_rsp_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign do_rd    = rd_en_i && (count_q != '0);
    assign do_wr    = wr_en_i && ((count_q != FULL_CNT) || do_rd);
    assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/modmult_scheduler.sv
// Round-robin front end sharing one fixed-latency modular-multiply pipeline among
// NUM_REQ requesters; results return in issue order through a credited FIFO.
module modmult_scheduler
    import modmult_sched_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 18,
    parameter int  PIPE_LAT   = DEF_PIPE_LAT,
    parameter int  MODULUS    = DEF_MODULUS,
    parameter int  FIFO_DEPTH = 16,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         mm_op,
    input  logic [DATA_WIDTH-1:0]         mm_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ID_W + 1 + DATA_WIDTH;

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       winner, cand;
    logic                  found, credit, issue, retire, pop;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] mm_op_q, mm_op_d;
    logic [CW-1:0]         inflight_q, inflight_d, fifo_count;
    logic [CW:0]           used;
    tag_t                  issue_tag, tag_out;
    tag_t                  tag_pipe_q [PIPE_LAT+1];
    logic                  fifo_empty;
    logic [ENT_W-1:0]      fifo_wdata, fifo_rdata;
    logic                  unused_tag_id;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = (cand == ID_W'(NUM_REQ-1)) ? '0 : cand + 1'b1;
        end
    end

    // A pop this cycle frees a slot, so it counts toward credit immediately.
    assign pop     = rsp_valid & rsp_ready;
    assign used    = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit  = used < ((CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop});
    assign issue   = found & credit & ~reset;
    assign operand = req_data[winner*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[winner] = 1'b1;
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = issue;
        issue_tag.id    = TAG_ID_W'(winner);
        issue_tag.err   = issue && (64'(operand) >= 64'(MODULUS));
    end

    // Stage 0 lines up with mm_op; the last stage lines up with mm_result.
    assign tag_out    = tag_pipe_q[PIPE_LAT];
    assign retire     = tag_out.valid;
    assign mm_op_d    = issue ? operand : mm_op_q;
    assign rr_ptr_d   = !issue ? rr_ptr_q :
                        (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    assign inflight_d = inflight_q + CW'(issue) - CW'(retire);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            mm_op_q    <= '0;
            inflight_q <= '0;
            for (int s = 0; s <= PIPE_LAT; s++) tag_pipe_q[s] <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            mm_op_q       <= mm_op_d;
            inflight_q    <= inflight_d;
            tag_pipe_q[0] <= issue_tag;
            for (int s = 1; s <= PIPE_LAT; s++) tag_pipe_q[s] <= tag_pipe_q[s-1];
        end
    end

    assign fifo_wdata = {tag_out.id[ID_W-1:0], tag_out.err, mm_result};

    modmult_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (retire),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign mm_op         = mm_op_q;
    assign rsp_valid     = ~fifo_empty & ~reset;
    assign rsp_id        = rsp_valid ? fifo_rdata[ENT_W-1 -: ID_W] : '0;
    assign rsp_err       = rsp_valid & fifo_rdata[DATA_WIDTH];
    assign rsp_data      = rsp_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
    assign unused_tag_id = ^tag_out.id;

endmodule

// File: doc/modmult_scheduler.md
MODMULT_SCHEDULER -- requirements
Module: modmult_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one modular-multiply-by-constant pipeline.
REQ-002 Parameter DATA_WIDTH, default 18: operand and result width.
REQ-003 Parameter PIPE_LAT, default 7: fixed latency of the pipeline from operand to result, in clocks.
REQ-004 Parameter MODULUS, default 177147: modulus of the shared pipeline.
REQ-005 Parameter FIFO_DEPTH, default 16: result FIFO entries, a power of two.
REQ-006 clk  in  1  the single clock; all logic is on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-009 req_data  in  NUM_REQ*DATA_WIDTH  per-requester operand; requester i occupies slice i.
REQ-010 req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
REQ-011 mm_op  out  DATA_WIDTH  registered operand driven to the shared pipeline.
REQ-012 mm_result  in  DATA_WIDTH  pipeline result, valid PIPE_LAT clocks after mm_op.
REQ-013 rsp_valid  out  1  a response is available.
REQ-014 rsp_ready  in  1  the consumer accepts the response.
REQ-015 rsp_id  out  clog2(NUM_REQ)  originating requester.
REQ-016 rsp_data  out  DATA_WIDTH  modular product.
REQ-017 rsp_err  out  1  the operand was >= MODULUS, so rsp_data is undefined.

Function
REQ-018 A handshake occurs on requester i when req_valid[i] & req_ready[i] are both high; at most one handshake occurs per cycle.
REQ-019 Arbitration is round-robin: search starts at rr_ptr, and rr_ptr becomes winner+1 (mod NUM_REQ) after each grant.
REQ-020 req_ready[i] is asserted only for the arbitration winner and only when credit is available; it does not depend on req_valid of any other requester once granted.
REQ-021 Credit is available when inflight_cnt + fifo_count < FIFO_DEPTH, evaluated with the same-cycle FIFO pop included.
REQ-022 On a handshake at cycle T, mm_op = operand at T+1, and a tag {valid, id, err} enters a PIPE_LAT-deep tag shift register aligned with the pipeline.
REQ-023 When the tag emerges valid, {id, err, mm_result} is written to the result FIFO in that cycle, and inflight_cnt is decremented.
REQ-024 With no backpressure, rsp_valid is asserted exactly PIPE_LAT+2 cycles after the handshake.
REQ-025 Non-handshake cycles insert an invalid tag; mm_op holds its previous value.
REQ-026 Responses leave in issue order; a response pops when rsp_valid & rsp_ready.
REQ-027 If a FIFO write and a pop occur in the same cycle, both take effect.
REQ-028 If a FIFO write and a pop occur in the same cycle while the FIFO is full, both take effect; overflow never occurs because of credit.
REQ-029 inflight_cnt is incremented and decremented in the same cycle without net change when an issue and a retire coincide.
REQ-030 fifo_count and inflight_cnt are clog2(FIFO_DEPTH)+1 bits wide.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-032 rsp_err = (operand >= MODULUS), computed at issue.

Reset
REQ-033 While reset is high: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, mm_op=0, rr_ptr=0, all tags invalid, FIFO empty, inflight_cnt=0.
REQ-034 Reset asserted mid-operation discards all in-flight work, including pipeline results returned after the reset.

Structure
REQ-035 Package modmult_sched_pkg holds the tag struct {valid, id, err} and the default constants (PIPE_LAT=7, MODULUS=177147).
REQ-036 The result FIFO is a sub-module, modmult_rsp_fifo, with synchronous reset and count output.

Verification
REQ-037 Single request, requester 2, operand 5, rsp_ready=1 -> exactly one response at T+9 with rsp_id=2, rsp_err=0, and rsp_data equal to the golden model value (5*C mod 177147).
REQ-038 All four requesters valid continuously -> grants follow 0,1,2,3,0,...; responses arrive in the same order, one per cycle.
REQ-039 rsp_ready=0 with continuous requests -> exactly 16 handshakes, then req_ready stays 0; after rsp_ready is raised, all 16 responses drain in order and none is lost.
REQ-040 Operand 177147 -> rsp_err=1; operand 177146 -> rsp_err=0 and rsp_data matches the golden model.
REQ-041 Reset pulsed 3 cycles after 4 issues -> no rsp_valid in the following 20 cycles, and inflight_cnt=0.
REQ-042 FIFO full with a simultaneous retire and pop -> fifo_count stays 16, and the next response carries the oldest entry.
